// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: independent conflict/sequence/timing monitor for the
// highway and side_road aspect buses. The first fault is latched with a code
// and an input snapshot, and flash_en commands flashing red until fault_clr.
// Optional macro TRAFFIC_MON_FAULT_CNT_EN adds a saturating fault_cnt output.
module traffic_light_monitor #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MIN_CLEAR  = 1,
  parameter int unsigned MAX_STUCK  = 200,
  parameter int unsigned PERSIST    = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] highway,
  input  logic [2:0] side_road,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic [2:0] snap_hw,
  output logic [2:0] snap_sr
`ifdef TRAFFIC_MON_FAULT_CNT_EN
  ,
  output logic [7:0] fault_cnt
`endif
);

  localparam int unsigned PER_W = 4;
  localparam logic [2:0] ASP_RED = 3'b100;
  localparam logic [2:0] ASP_YEL = 3'b010;
  localparam logic [2:0] ASP_GRN = 3'b001;

  typedef enum logic [1:0] {MON_INIT, MON_RUN, MON_FAULT} state_t;

  state_t           state;
  logic [2:0]       hw_q, sr_q, hw_p, sr_p;
  logic [CNT_W-1:0] yel_hw_cnt, yel_sr_cnt, clr_cnt, idle_cnt;
  logic [PER_W-1:0] inv_cnt, cnf_cnt;
  logic             inv_cond, cnf_cond, pair_ok, changed, both_red;
  logic [2:0]       hit_code;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == ASP_RED) || (v == ASP_YEL) || (v == ASP_GRN);
  endfunction

  // Both roads legal and at least one of them red.
  function automatic logic clean(input logic [2:0] h, input logic [2:0] s);
    return one_hot3(h) && one_hot3(s) && ((h == ASP_RED) || (s == ASP_RED));
  endfunction

  function automatic logic step_ok(input logic [2:0] p, input logic [2:0] q);
    return (p == q) ||
           ((p == ASP_GRN) && (q == ASP_YEL)) ||
           ((p == ASP_YEL) && (q == ASP_RED)) ||
           ((p == ASP_RED) && (q == ASP_GRN));
  endfunction

  // Evaluate all checks on the current sample; lowest code wins. Sequence and
  // timing checks only apply between two clean samples so that a short glitch
  // is left to the persistence filter instead of tripping a sequence fault.
  always_comb begin
    inv_cond = !one_hot3(hw_q) || !one_hot3(sr_q);
    cnf_cond = !inv_cond && (hw_q != ASP_RED) && (sr_q != ASP_RED);
    pair_ok  = clean(hw_q, sr_q) && clean(hw_p, sr_p);
    changed  = (hw_q != hw_p) || (sr_q != sr_p);
    both_red = (hw_q == ASP_RED) && (sr_q == ASP_RED);
    hit_code = 3'd0;
    if (inv_cond && (inv_cnt >= PER_W'(PERSIST - 1))) begin
      hit_code = 3'd1;
    end else if (cnf_cond && (cnf_cnt >= PER_W'(PERSIST - 1))) begin
      hit_code = 3'd2;
    end else if (pair_ok && (!step_ok(hw_p, hw_q) || !step_ok(sr_p, sr_q))) begin
      hit_code = 3'd3;
    end else if (pair_ok &&
                 (((hw_p == ASP_YEL) && (hw_q != ASP_YEL) && (yel_hw_cnt < CNT_W'(MIN_YELLOW))) ||
                  ((sr_p == ASP_YEL) && (sr_q != ASP_YEL) && (yel_sr_cnt < CNT_W'(MIN_YELLOW))))) begin
      hit_code = 3'd4;
    end else if (pair_ok &&
                 (((hw_p == ASP_RED) && (hw_q == ASP_GRN)) ||
                  ((sr_p == ASP_RED) && (sr_q == ASP_GRN))) &&
                 (clr_cnt < CNT_W'(MIN_CLEAR))) begin
      hit_code = 3'd5;
    end else if (!changed && (idle_cnt >= CNT_W'(MAX_STUCK - 1))) begin
      hit_code = 3'd6;
    end
  end

  // Sample history, monitor FSM, timing counters and latched fault outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MON_INIT;
      hw_q       <= '0;
      sr_q       <= '0;
      hw_p       <= '0;
      sr_p       <= '0;
      yel_hw_cnt <= '0;
      yel_sr_cnt <= '0;
      clr_cnt    <= '0;
      idle_cnt   <= '0;
      inv_cnt    <= '0;
      cnf_cnt    <= '0;
      fault      <= 1'b0;
      flash_en   <= 1'b0;
      fault_code <= 3'd0;
      snap_hw    <= 3'd0;
      snap_sr    <= 3'd0;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
      fault_cnt  <= 8'd0;
`endif
    end else begin
      hw_q <= highway;
      sr_q <= side_road;
      hw_p <= hw_q;
      sr_p <= sr_q;
      case (state)
        MON_INIT: begin
          yel_hw_cnt <= '0;
          yel_sr_cnt <= '0;
          clr_cnt    <= '0;
          idle_cnt   <= '0;
          inv_cnt    <= '0;
          cnf_cnt    <= '0;
          if (clean(hw_q, sr_q)) begin
            state <= MON_RUN;
          end
        end
        MON_RUN: begin
          if (hit_code != 3'd0) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            flash_en   <= 1'b1;
            fault_code <= hit_code;
            snap_hw    <= hw_q;
            snap_sr    <= sr_q;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
            fault_cnt  <= (&fault_cnt) ? fault_cnt : fault_cnt + 8'd1;
`endif
          end else begin
            yel_hw_cnt <= (hw_q != ASP_YEL) ? '0 :
                          ((&yel_hw_cnt) ? yel_hw_cnt : yel_hw_cnt + CNT_W'(1));
            yel_sr_cnt <= (sr_q != ASP_YEL) ? '0 :
                          ((&yel_sr_cnt) ? yel_sr_cnt : yel_sr_cnt + CNT_W'(1));
            clr_cnt    <= !both_red ? '0 :
                          ((&clr_cnt) ? clr_cnt : clr_cnt + CNT_W'(1));
            idle_cnt   <= changed ? '0 :
                          ((idle_cnt >= CNT_W'(MAX_STUCK)) ? idle_cnt : idle_cnt + CNT_W'(1));
            inv_cnt    <= !inv_cond ? '0 :
                          ((&inv_cnt) ? inv_cnt : inv_cnt + PER_W'(1));
            cnf_cnt    <= !cnf_cond ? '0 :
                          ((&cnf_cnt) ? cnf_cnt : cnf_cnt + PER_W'(1));
          end
        end
        MON_FAULT: begin
          if (fault_clr) begin
            state      <= MON_INIT;
            fault      <= 1'b0;
            flash_en   <= 1'b0;
            fault_code <= 3'd0;
            snap_hw    <= 3'd0;
            snap_sr    <= 3'd0;
          end
        end
        default: state <= MON_INIT;
      endcase
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Independent conflict monitor on the receiving end of the traffic_light_controller light outputs.
- Samples the highway and side_road aspect buses every clock and checks legality, sequence and minimum timings.
- Latches the first fault with a code and snapshot, and raises flash_en so the signal heads can be forced to flashing red.
- Sits beside the controller at top level, sharing its clock and reset.

Parameters:
- MIN_YELLOW, 3, minimum consecutive cycles a road must show yellow.
- MIN_CLEAR, 1, minimum all-red cycles before either road may turn green.
- MAX_STUCK, 200, cycles without any aspect change before a stuck fault.
- PERSIST, 2, consecutive samples an invalid/conflict condition must hold before latching (glitch filter, 1..15).
- CNT_W, 8, width of the internal timing counters; must hold MAX_STUCK.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  synchronous, active-high reset.
- highway  input  3  highway aspect {red, yellow, green} (bit2 = red, bit1 = yellow, bit0 = green).
- side_road  input  3  side road aspect, same encoding.
- fault_clr  input  1  one-cycle pulse that clears a latched fault.
- fault  output  1  a fault is latched.
- fault_code  output  3  0 = none, 1 = invalid aspect, 2 = conflict, 3 = illegal sequence, 4 = short yellow, 5 = short clearance, 6 = stuck.
- flash_en  output  1  equals fault; commands flashing red.
- snap_hw  output  3  highway value at the fault-latching sample.
- snap_sr  output  3  side_road value at the fault-latching sample.

Behaviour:
- Reset: on a clock edge with rst = 1, all outputs go to 0, all counters clear and state = MON_INIT. rst overrides fault_clr and any pending detection, including mid-fault.
- Sampling and history: inputs are registered each cycle into hw_q/sr_q; the previous sample is held as hw_p/sr_p.
- Legal aspect: a road's value is legal when it is exactly one-hot.
- MON_INIT:
  - Waits for one sample where both roads are legal and at least one is red.
  - Then loads history, clears counters and moves to MON_RUN.
  - No faults are raised in MON_INIT.
- MON_RUN checks (all evaluated on the current sample against the history):
  - Code 1, invalid aspect: either road not one-hot for PERSIST consecutive samples.
  - Code 2, conflict: both roads non-red (and legal) for PERSIST consecutive samples.
  - Code 3, illegal sequence: a road changes other than green->yellow, yellow->red or red->green.
  - Code 4, short yellow: a road leaves yellow with yel_cnt < MIN_YELLOW. yel_cnt counts samples of continuous yellow on that road (one counter per road).
  - Code 5, short clearance: a road goes red->green with clr_cnt < MIN_CLEAR. clr_cnt counts consecutive both-red samples and clears on any non-red sample.
  - Code 6, stuck: idle_cnt reaches MAX_STUCK. idle_cnt clears on any change of either road and saturates at MAX_STUCK.
  - Persistence counters reset on any sample without the condition.
- Fault latching:
  - If several checks fire on the same sample, the lowest code wins.
  - fault, flash_en, fault_code, snap_hw and snap_sr update on the edge following the triggering sample (one-cycle latency), then state = MON_FAULT.
- MON_FAULT:
  - All outputs hold and further violations are ignored (first fault only).
  - fault_clr = 1 clears fault, flash_en, fault_code and the snapshots to 0 on the next edge and returns to MON_INIT.
  - fault_clr in MON_INIT or MON_RUN is ignored.
- Counters saturate at their maximum and never wrap.

Optional Feature:
- Macro: TRAFFIC_MON_FAULT_CNT_EN.
- Defined:
  - Adds output fault_cnt [7:0], incremented each time a fault latches, saturating at 255.
  - Cleared only by rst, not by fault_clr.
- Undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Legal cycle: highway G(10), Y(3), R with side R, side_road G(10) after 1 all-red cycle, repeated twice -> fault = 0 throughout, fault_code = 0.
- Conflict: highway = 001, side_road = 001 for 2 cycles -> fault = 1 one edge after the 2nd sample, fault_code = 2, snap_hw = 001, snap_sr = 001, flash_en = 1. A 1-cycle conflict glitch -> no fault.
- Sequence/yellow: highway 001 -> 100 directly -> code 3. Separately, highway yellow for 2 cycles with MIN_YELLOW = 3 -> code 4.
- Stuck and priority: hold a legal state 200 cycles -> code 6. Invalid highway = 011 with side = 001 held 2 cycles -> code 1 (beats 2).
- Clear/reset: from a latched fault, pulse fault_clr -> outputs 0 next edge and re-arm after a legal sample. Assert rst mid-fault -> all outputs 0 next edge. With TRAFFIC_MON_FAULT_CNT_EN, 3 faults give fault_cnt = 3, unchanged by fault_clr.
